// File: rtl/byte_striping_rx_4l_pkg.sv
// Shared constants for the 4-lane byte striping stages (RX striping, TX un-striping).
// State encoding, lane count, default pad byte and lane-mask helper.
package byte_striping_rx_4l_pkg;

    localparam int unsigned LANES = 4;
    localparam logic [7:0] PAD_BYTE_DEF = 8'hF7;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        WAIT    = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        SEL_HOLD   = 2'd0,
        SEL_STAGED = 2'd1,
        SEL_LIVE   = 2'd2,
        SEL_PAD    = 2'd3
    } lane_sel_e;

    // Lanes below the staged count carry real data.
    function automatic logic [3:0] fill_mask(input logic [1:0] n);
        logic [3:0] m;
        unique case (n)
            2'd0: m = 4'b0000;
            2'd1: m = 4'b0001;
            2'd2: m = 4'b0011;
            2'd3: m = 4'b0111;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/byte_striping_rx_4l_lane.sv
// One lane output register: holds, or loads a staged byte, the live byte or the pad.
// With LANE_PARITY_EN defined, also registers the even parity of the loaded byte.
module stripe_lane_reg
    import byte_striping_rx_4l_pkg::*;
#(
    parameter logic [7:0] PAD_BYTE = PAD_BYTE_DEF
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  lane_sel_e  sel_i,
    input  logic [7:0] staged_i,
    input  logic [7:0] live_i,
    output logic [7:0] data_o
`ifdef LANE_PARITY_EN
    ,
    output logic       parity_o
`endif
);

    logic [7:0] data_q, data_d;

    always_comb begin
        data_d = data_q;
        unique case (sel_i)
            SEL_HOLD:   data_d = data_q;
            SEL_STAGED: data_d = staged_i;
            SEL_LIVE:   data_d = live_i;
            SEL_PAD:    data_d = PAD_BYTE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) data_q <= 8'h00;
        else         data_q <= data_d;
    end

    assign data_o = data_q;

`ifdef LANE_PARITY_EN
    logic par_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) par_q <= 1'b0;
        else         par_q <= ^data_d;
    end

    assign parity_o = par_q;
`endif

endmodule

// File: rtl/byte_striping_rx_4l.sv
// Round-robin byte striping onto 4 lanes, with padded flush of partial groups.
// Optional per-lane parity output when LANE_PARITY_EN is defined.
module byte_striping_rx_4l
    import byte_striping_rx_4l_pkg::*;
#(
    parameter logic [7:0]  PAD_BYTE    = PAD_BYTE_DEF,
    parameter int unsigned FLUSH_DELAY = 0
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic       valid_in,
    input  logic [7:0] data_in,
    output logic [7:0] data0,
    output logic [7:0] data1,
    output logic [7:0] data2,
    output logic [7:0] data3,
    output logic       valid_out,
    output logic [3:0] lane_mask
`ifdef LANE_PARITY_EN
    ,
    output logic [3:0] parity_out
`endif
);

    localparam logic [3:0] FD = FLUSH_DELAY[3:0];

    state_e     state_q, state_d;
    logic [1:0] ptr_q, ptr_d;
    logic [3:0] idle_q, idle_d;
    logic [7:0] s_q [3];
    logic [7:0] s_d [3];
    logic       valid_q, valid_d;
    logic [3:0] mask_q, mask_d;
    logic       complete, flush;
    lane_sel_e  lane_sel [LANES];
    logic [7:0] stg [LANES];
    logic [7:0] lane_data [LANES];

    assign complete = valid_in && (state_q != IDLE) && (ptr_q == 2'd3);
    // With no delay the flush happens on the first idle edge, straight from COLLECT.
    assign flush = !valid_in &&
                   (((state_q == COLLECT) && (FD == 4'd0)) ||
                    ((state_q == WAIT) && (idle_q == FD)));

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= 2'd0;
            idle_q  <= 4'd0;
            s_q     <= '{default: 8'h00};
            valid_q <= 1'b0;
            mask_q  <= 4'b0000;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idle_q  <= idle_d;
            s_q     <= s_d;
            valid_q <= valid_d;
            if (valid_d) mask_q <= mask_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idle_d  = idle_q;
        s_d     = s_q;
        unique case (state_q)
            IDLE: begin
                if (valid_in) begin
                    s_d[0]  = data_in;
                    ptr_d   = 2'd1;
                    state_d = COLLECT;
                end
            end
            COLLECT, WAIT: begin
                if (valid_in) begin
                    idle_d = 4'd0;
                    if (ptr_q == 2'd3) begin
                        ptr_d   = 2'd0;
                        state_d = IDLE;
                    end else begin
                        for (int i = 0; i < 3; i++)
                            if (ptr_q == 2'(i)) s_d[i] = data_in;
                        ptr_d   = ptr_q + 2'd1;
                        state_d = COLLECT;
                    end
                end else if (flush) begin
                    ptr_d   = 2'd0;
                    idle_d  = 4'd0;
                    state_d = IDLE;
                end else if (state_q == COLLECT) begin
                    idle_d  = 4'd1;
                    state_d = WAIT;
                end else begin
                    idle_d = idle_q + 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
                ptr_d   = 2'd0;
                idle_d  = 4'd0;
            end
        endcase
    end

    always_comb begin
        valid_d = complete || flush;
        mask_d  = complete ? 4'b1111 : fill_mask(ptr_q);
        for (int i = 0; i < LANES; i++) begin
            lane_sel[i] = SEL_HOLD;
            if (complete)
                lane_sel[i] = (i == LANES - 1) ? SEL_LIVE : SEL_STAGED;
            else if (flush)
                lane_sel[i] = (2'(i) < ptr_q) ? SEL_STAGED : SEL_PAD;
        end
    end

    assign stg = '{s_q[0], s_q[1], s_q[2], PAD_BYTE};

`ifdef LANE_PARITY_EN
    logic [LANES-1:0] lane_par;
`endif

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        stripe_lane_reg #(
            .PAD_BYTE(PAD_BYTE)
        ) u_lane (
            .clk_i   (CLK),
            .reset_i (reset),
            .sel_i   (lane_sel[i]),
            .staged_i(stg[i]),
            .live_i  (data_in),
            .data_o  (lane_data[i])
`ifdef LANE_PARITY_EN
            ,
            .parity_o(lane_par[i])
`endif
        );
    end

`ifdef LANE_PARITY_EN
    assign parity_out = lane_par;
`endif

    assign data0     = lane_data[0];
    assign data1     = lane_data[1];
    assign data2     = lane_data[2];
    assign data3     = lane_data[3];
    assign valid_out = valid_q;
    assign lane_mask = mask_q;

endmodule

// File: tb/tb_byte_striping_rx_4l.sv
// Bench for byte_striping_rx_4l: two instances (FLUSH_DELAY 0 and 3) on shared stimulus.
// Directed scenarios use fixed expectations; random traffic uses a group-level model.
module tb_byte_striping_rx_4l;

    logic       clk = 1'b0;
    logic       rst;
    logic       vin;
    logic [7:0] din;

    logic [7:0] a0, a1, a2, a3, b0, b1, b2, b3;
    logic       va, vb;
    logic [3:0] ma, mb;
`ifdef LANE_PARITY_EN
    logic [3:0] pa, pb;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    byte_striping_rx_4l #(.PAD_BYTE(8'hF7), .FLUSH_DELAY(0)) u0 (
        .CLK(clk), .reset(rst), .valid_in(vin), .data_in(din),
        .data0(a0), .data1(a1), .data2(a2), .data3(a3),
        .valid_out(va), .lane_mask(ma)
`ifdef LANE_PARITY_EN
        , .parity_out(pa)
`endif
    );

    byte_striping_rx_4l #(.PAD_BYTE(8'hF7), .FLUSH_DELAY(3)) u3 (
        .CLK(clk), .reset(rst), .valid_in(vin), .data_in(din),
        .data0(b0), .data1(b1), .data2(b2), .data3(b3),
        .valid_out(vb), .lane_mask(mb)
`ifdef LANE_PARITY_EN
        , .parity_out(pb)
`endif
    );

    // Group-level reference: a list of bytes and a run length of idle cycles.
    int         fd [2] = '{0, 3};
    logic [7:0] grp [2][4];
    int         cnt [2];
    int         idl [2];
    logic [7:0] ed [2][4];
    logic [3:0] em [2];
    logic       ev [2];

    task automatic model_edge(input logic r, input logic v, input logic [7:0] d);
        for (int k = 0; k < 2; k++) begin
            ev[k] = 1'b0;
            if (r) begin
                cnt[k] = 0;
                idl[k] = 0;
                for (int i = 0; i < 4; i++) ed[k][i] = 8'h00;
                em[k] = 4'b0000;
            end else begin
                logic emit;
                emit = 1'b0;
                if (v) begin
                    grp[k][cnt[k]] = d;
                    cnt[k]++;
                    idl[k] = 0;
                    emit = (cnt[k] == 4);
                end else if (cnt[k] > 0) begin
                    idl[k]++;
                    emit = (idl[k] == fd[k] + 1);
                end
                if (emit) begin
                    for (int i = 0; i < 4; i++)
                        ed[k][i] = (i < cnt[k]) ? grp[k][i] : 8'hF7;
                    em[k] = 4'((1 << cnt[k]) - 1);
                    ev[k] = 1'b1;
                    cnt[k] = 0;
                    idl[k] = 0;
                end
            end
        end
    endtask

    task automatic step(input logic r, input logic v, input logic [7:0] d);
        rst = r;
        vin = v;
        din = d;
        @(posedge clk);
        model_edge(r, v, d);
        #1;
    endtask

    task automatic test_reset();
        step(1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b0, 8'h00);
        checks++;
        if ({va, ma, a0, a1, a2, a3} !== 37'h0) begin
            errors++;
            $display("FAIL reset_u0 got=%h want=0", {va, ma, a0, a1, a2, a3});
        end
        checks++;
        if ({vb, mb, b0, b1, b2, b3} !== 37'h0) begin
            errors++;
            $display("FAIL reset_u3 got=%h want=0", {vb, mb, b0, b1, b2, b3});
        end
`ifdef LANE_PARITY_EN
        checks++;
        if (pa !== 4'b0000) begin
            errors++;
            $display("FAIL reset_par got=%b want=0000", pa);
        end
`endif
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 8'h00);
            checks++;
            if (va !== 1'b0 || vb !== 1'b0) begin
                errors++;
                $display("FAIL idle_after_reset got=%b%b want=00", va, vb);
            end
        end
    endtask

    task automatic test_group();
        step(1'b0, 1'b1, 8'h11);
        step(1'b0, 1'b1, 8'h22);
        step(1'b0, 1'b1, 8'h33);
        checks++;
        if (va !== 1'b0) begin
            errors++;
            $display("FAIL group_early got=%b want=0", va);
        end
        step(1'b0, 1'b1, 8'h44);
        checks++;
        if ({va, ma, a0, a1, a2, a3} !== {1'b1, 4'b1111, 32'h11223344}) begin
            errors++;
            $display("FAIL group_u0 got=%h want=%h",
                     {va, ma, a0, a1, a2, a3}, {1'b1, 4'b1111, 32'h11223344});
        end
        checks++;
        if ({vb, mb, b0, b1, b2, b3} !== {1'b1, 4'b1111, 32'h11223344}) begin
            errors++;
            $display("FAIL group_u3 got=%h", {vb, mb, b0, b1, b2, b3});
        end
`ifdef LANE_PARITY_EN
        checks++;
        if (pa !== 4'b0000) begin
            errors++;
            $display("FAIL group_par got=%b want=0000", pa);
        end
`endif
        step(1'b0, 1'b0, 8'h00);
        checks++;
        if ({va, ma, a0, a1, a2, a3} !== {1'b0, 4'b1111, 32'h11223344}) begin
            errors++;
            $display("FAIL group_hold got=%h", {va, ma, a0, a1, a2, a3});
        end
    endtask

    task automatic test_back_to_back();
        int pulses = 0;
        for (int i = 1; i <= 8; i++) begin
            step(1'b0, 1'b1, 8'(i));
            if (va) begin
                pulses++;
                checks++;
                if (i != 4 && i != 8) begin
                    errors++;
                    $display("FAIL b2b_timing got=byte%0d want=byte4_or_8", i);
                end else if ({a0, a1, a2, a3} !== (i == 4 ? 32'h01020304 : 32'h05060708)) begin
                    errors++;
                    $display("FAIL b2b_data got=%h at=%0d", {a0, a1, a2, a3}, i);
                end
            end
        end
        checks++;
        if (pulses != 2) begin
            errors++;
            $display("FAIL b2b_pulses got=%0d want=2", pulses);
        end
        step(1'b0, 1'b0, 8'h00);
    endtask

    task automatic test_flush0();
        step(1'b0, 1'b1, 8'hAA);
        step(1'b0, 1'b1, 8'hBB);
        step(1'b0, 1'b0, 8'h00);
        checks++;
        if ({va, ma, a0, a1, a2, a3} !== {1'b1, 4'b0011, 32'hAABBF7F7}) begin
            errors++;
            $display("FAIL flush0 got=%h want=%h",
                     {va, ma, a0, a1, a2, a3}, {1'b1, 4'b0011, 32'hAABBF7F7});
        end
`ifdef LANE_PARITY_EN
        checks++;
        if (pa !== 4'b1100) begin
            errors++;
            $display("FAIL flush0_par got=%b want=1100", pa);
        end
`endif
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'h00);
        checks++;
        if ({vb, mb, b0, b1, b2, b3} !== {1'b1, 4'b0011, 32'hAABBF7F7}) begin
            errors++;
            $display("FAIL flush0_u3 got=%h", {vb, mb, b0, b1, b2, b3});
        end
    endtask

    task automatic test_flush3();
        step(1'b0, 1'b1, 8'h5A);
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 1'b0, 8'h00);
            checks++;
            if (vb !== 1'b0) begin
                errors++;
                $display("FAIL flush3_gap got=%b want=0", vb);
            end
        end
        step(1'b0, 1'b1, 8'h5B);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 8'h00);
            checks++;
            if (vb !== 1'b0) begin
                errors++;
                $display("FAIL flush3_early got=%b want=0 idle=%0d", vb, i + 1);
            end
        end
        step(1'b0, 1'b0, 8'h00);
        checks++;
        if ({vb, mb, b0, b1, b2, b3} !== {1'b1, 4'b0011, 32'h5A5BF7F7}) begin
            errors++;
            $display("FAIL flush3 got=%h want=%h",
                     {vb, mb, b0, b1, b2, b3}, {1'b1, 4'b0011, 32'h5A5BF7F7});
        end
    endtask

    task automatic test_reset_mid();
        int pulses = 0;
        step(1'b0, 1'b1, 8'hC1);
        step(1'b0, 1'b1, 8'hC2);
        step(1'b0, 1'b1, 8'hC3);
        step(1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, 8'hD1 + 8'(i));
            if (va) pulses++;
        end
        checks++;
        if ({va, ma, a0, a1, a2, a3} !== {1'b1, 4'b1111, 32'hD1D2D3D4} || pulses != 1) begin
            errors++;
            $display("FAIL reset_mid got=%h pulses=%0d want=%h pulses=1",
                     {va, ma, a0, a1, a2, a3}, pulses, {1'b1, 4'b1111, 32'hD1D2D3D4});
        end
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 8'h00);
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            step(($urandom % 100) == 0, ($urandom % 100) < 60, 8'($urandom));
            checks++;
            if ({va, ma, a0, a1, a2, a3} !==
                {ev[0], em[0], ed[0][0], ed[0][1], ed[0][2], ed[0][3]}) begin
                errors++;
                $display("FAIL rand_u0 n=%0d got=%h want=%h", n, {va, ma, a0, a1, a2, a3},
                         {ev[0], em[0], ed[0][0], ed[0][1], ed[0][2], ed[0][3]});
            end
            checks++;
            if ({vb, mb, b0, b1, b2, b3} !==
                {ev[1], em[1], ed[1][0], ed[1][1], ed[1][2], ed[1][3]}) begin
                errors++;
                $display("FAIL rand_u3 n=%0d got=%h want=%h", n, {vb, mb, b0, b1, b2, b3},
                         {ev[1], em[1], ed[1][0], ed[1][1], ed[1][2], ed[1][3]});
            end
`ifdef LANE_PARITY_EN
            checks++;
            if (pb !== {^ed[1][3], ^ed[1][2], ^ed[1][1], ^ed[1][0]}) begin
                errors++;
                $display("FAIL rand_par n=%0d got=%b", n, pb);
            end
`endif
        end
    endtask

    initial begin
        rst = 1'b1;
        vin = 1'b0;
        din = 8'h00;
        test_reset();
        test_group();
        test_back_to_back();
        test_flush0();
        test_flush3();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
